// File: rtl/jamma_pkg.sv
// Shared types and constants for the JAMMA player-input scanner.
// Used by jamma_input_scanner and jamma_debounce.
package jamma_pkg;

  typedef enum logic [1:0] {
    P1_SETTLE = 2'd0,
    P1_SAMPLE = 2'd1,
    P2_SETTLE = 2'd2,
    P2_SAMPLE = 2'd3
  } scan_state_e;

  localparam logic [7:0] JOY_IDLE = 8'hFF;

  // Bit positions on the active-low player bus
  localparam int JOY_UP    = 0;
  localparam int JOY_DOWN  = 1;
  localparam int JOY_LEFT  = 2;
  localparam int JOY_RIGHT = 3;
  localparam int JOY_B1    = 4;
  localparam int JOY_B2    = 5;
  localparam int JOY_B3    = 6;
  localparam int JOY_START = 7;

  function automatic logic is_p2_state(scan_state_e s);
    return (s == P2_SETTLE) || (s == P2_SAMPLE);
  endfunction

endpackage

// File: rtl/jamma_debounce.sv
// Per-bit coin level filter: the output follows the input only after
// DEBOUNCE_CNT consecutive equal samples.
module jamma_debounce
  import jamma_pkg::*;
#(
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sample,
  input  logic din,
  output logic dout
);

  localparam logic [3:0] CNT_MAX = 4'(DEBOUNCE_CNT);

  logic [3:0] run_cnt_reg, run_cnt_next;
  logic       level_reg, level_next;
  logic       dout_reg, dout_next;

  always_comb begin
    run_cnt_next = run_cnt_reg;
    level_next   = level_reg;
    dout_next    = dout_reg;
    if (sample) begin
      if (din == level_reg) begin
        if (run_cnt_reg != CNT_MAX) run_cnt_next = run_cnt_reg + 4'd1;
      end else begin
        // A differing scan starts a new run that already counts as one
        level_next   = din;
        run_cnt_next = 4'd1;
      end
      if (run_cnt_next == CNT_MAX) dout_next = level_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt_reg <= 4'd0;
      level_reg   <= 1'b1;
      dout_reg    <= 1'b1;
    end else begin
      run_cnt_reg <= run_cnt_next;
      level_reg   <= level_next;
      dout_reg    <= dout_next;
    end
  end

  assign dout = dout_reg;

endmodule

// File: rtl/jamma_input_scanner.sv
// Time-multiplexed JAMMA two-player input scanner with coin synchronizer.
// Optional coin debounce is built when JAMMA_COIN_DEBOUNCE_EN is defined.
module jamma_input_scanner
  import jamma_pkg::*;
#(
  parameter int SETTLE_CYCLES = 8,
  parameter int DEBOUNCE_CNT  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] jjoy,
  input  logic [5:0] local_joy,
  input  logic [1:0] jcoin,
  output logic       jselect,
  output logic [7:0] joystick1,
  output logic [7:0] joystick2,
  output logic [1:0] coin,
  output logic       scan_done
);

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  scan_state_e state_reg, state_next;
  logic [7:0]  settle_cnt_reg, settle_cnt_next;
  logic        jselect_reg, jselect_next;
  logic [7:0]  joy1_reg, joy1_next;
  logic [7:0]  joy2_reg, joy2_next;
  logic        scan_done_reg, scan_done_next;
  logic [1:0]  coin_sync1_reg, coin_sync2_reg;

  always_comb begin
    state_next      = state_reg;
    settle_cnt_next = settle_cnt_reg;
    joy1_next       = joy1_reg;
    joy2_next       = joy2_reg;
    scan_done_next  = 1'b0;
    if (ena) begin
      unique case (state_reg)
        P1_SETTLE: begin
          if (settle_cnt_reg == SETTLE_LAST) begin
            state_next      = P1_SAMPLE;
            settle_cnt_next = 8'd0;
          end else begin
            settle_cnt_next = settle_cnt_reg + 8'd1;
          end
        end
        P1_SAMPLE: begin
          // On-board stick shares player 1; either source pressing wins
          joy1_next       = jjoy & {2'b11, local_joy};
          state_next      = P2_SETTLE;
          settle_cnt_next = 8'd0;
        end
        P2_SETTLE: begin
          if (settle_cnt_reg == SETTLE_LAST) begin
            state_next      = P2_SAMPLE;
            settle_cnt_next = 8'd0;
          end else begin
            settle_cnt_next = settle_cnt_reg + 8'd1;
          end
        end
        P2_SAMPLE: begin
          joy2_next       = jjoy;
          scan_done_next  = 1'b1;
          state_next      = P1_SETTLE;
          settle_cnt_next = 8'd0;
        end
        default: state_next = P1_SETTLE;
      endcase
    end
    // Select comes from a flop so the external mux never sees decode glitches
    jselect_next = is_p2_state(state_next);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= P1_SETTLE;
      settle_cnt_reg <= 8'd0;
      jselect_reg    <= 1'b0;
      joy1_reg       <= JOY_IDLE;
      joy2_reg       <= JOY_IDLE;
      scan_done_reg  <= 1'b0;
      coin_sync1_reg <= 2'b11;
      coin_sync2_reg <= 2'b11;
    end else begin
      scan_done_reg <= scan_done_next;
      if (ena) begin
        state_reg      <= state_next;
        settle_cnt_reg <= settle_cnt_next;
        jselect_reg    <= jselect_next;
        joy1_reg       <= joy1_next;
        joy2_reg       <= joy2_next;
        coin_sync1_reg <= jcoin;
        coin_sync2_reg <= coin_sync1_reg;
      end
    end
  end

  assign jselect   = jselect_reg;
  assign joystick1 = joy1_reg;
  assign joystick2 = joy2_reg;
  assign scan_done = scan_done_reg;

`ifdef JAMMA_COIN_DEBOUNCE_EN
  logic coin_sample;
  assign coin_sample = ena && (state_reg == P2_SAMPLE);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_coin_debounce
      jamma_debounce #(
        .DEBOUNCE_CNT(DEBOUNCE_CNT)
      ) u_debounce (
        .clk   (clk),
        .rst_n (rst_n),
        .sample(coin_sample),
        .din   (coin_sync2_reg[gi]),
        .dout  (coin[gi])
      );
    end
  endgenerate
`else
  assign coin = coin_sync2_reg;
`endif

endmodule

// File: tb/tb_jamma_input_scanner.sv
// Directed bench for jamma_input_scanner with a cycle-level reference model.
module tb_jamma_input_scanner;

  localparam int S = 8;
  localparam int P = 2 * (S + 1);
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ena = 1'b1;
  logic [7:0] jjoy;
  logic [7:0] p1_val = 8'hFE;
  logic [7:0] p2_val = 8'h7F;
  logic [5:0] local_joy = 6'h3F;
  logic [1:0] jcoin = 2'b11;
  logic       jselect, scan_done;
  logic [7:0] joystick1, joystick2;
  logic [1:0] coin;

  int  checks = 0;
  int  errors = 0;
  int  edge_cnt = 0;
  bit  chk_on = 1'b0;
  bit  toggle = 1'b0;

  jamma_input_scanner #(
    .SETTLE_CYCLES(S),
    .DEBOUNCE_CNT (D)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .jjoy     (jjoy),
    .local_joy(local_joy),
    .jcoin    (jcoin),
    .jselect  (jselect),
    .joystick1(joystick1),
    .joystick2(joystick2),
    .coin     (coin),
    .scan_done(scan_done)
  );

  always #5 clk = ~clk;

  // Player bus mux outside the chip
  always_comb jjoy = jselect ? p2_val : p1_val;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: everything derives from the count of enabled edges since reset
  int          en_edges;
  logic [7:0]  m_j1, m_j2;
  logic        m_sel, m_done;
  logic [1:0]  m_coin, s1, s2, lvl;
  logic [1:0]  scan_hist[$];

  initial begin
    en_edges = 0; m_j1 = 8'hFF; m_j2 = 8'hFF; m_sel = 0; m_done = 0;
    m_coin = 2'b11; s1 = 2'b11; s2 = 2'b11;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        edge_cnt = 0; en_edges = 0;
        m_j1 = 8'hFF; m_j2 = 8'hFF; m_sel = 0; m_done = 0;
        m_coin = 2'b11; s1 = 2'b11; s2 = 2'b11;
        scan_hist.delete();
      end else begin
        edge_cnt++;
        if (ena) begin
          int e;
          e = en_edges + 1;
          lvl = s2; s2 = s1; s1 = jcoin;
          m_done = (e % P == 0);
          if (e % P == S + 1) m_j1 = jjoy & {2'b11, local_joy};
          if (e % P == 0) begin
            m_j2 = jjoy;
`ifdef JAMMA_COIN_DEBOUNCE_EN
            scan_hist.push_front(lvl);
            if (scan_hist.size() > D) void'(scan_hist.pop_back());
            if (scan_hist.size() == D)
              for (int b = 0; b < 2; b++) begin
                bit same = 1'b1;
                foreach (scan_hist[k]) if (scan_hist[k][b] != lvl[b]) same = 1'b0;
                if (same) m_coin[b] = lvl[b];
              end
`endif
          end
          m_sel = (e % P) > S;
          en_edges = e;
`ifndef JAMMA_COIN_DEBOUNCE_EN
          m_coin = s2;
`endif
        end else begin
          m_done = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("jselect", int'(jselect), int'(m_sel));
      check("joystick1", int'(joystick1), int'(m_j1));
      check("joystick2", int'(joystick2), int'(m_j2));
      check("coin", int'(coin), int'(m_coin));
      check("scan_done", int'(scan_done), int'(m_done));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (toggle) ena = ~ena;
  endtask

  task automatic wait_done(output int cyc);
    bit found = 1'b0;
    cyc = -1;
    for (int i = 0; i < 200 && !found; i++) begin
      tick();
      if (scan_done === 1'b1) begin
        found = 1'b1;
        cyc = edge_cnt + 1;
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL scan_done_timeout: got none expected pulse within 200 cycles at %0t", $time);
    end
  endtask

  initial begin
    int c, c1, c2;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_on = 1'b1;
    check("rst_jselect", int'(jselect), 0);
    check("rst_joystick1", int'(joystick1), 'hFF);
    check("rst_joystick2", int'(joystick2), 'hFF);
    check("rst_coin", int'(coin), 'b11);
    check("rst_scan_done", int'(scan_done), 0);
    rst_n = 1'b1;

    wait_done(c);
    check("first_done_cycle", c, 19);
    check("p1_value", int'(joystick1), 'hFE);
    check("p2_value", int'(joystick2), 'h7F);
    wait_done(c);
    check("second_done_cycle", c, 37);
    $display("scan: joystick1=%h joystick2=%h done_cycle=%0d", joystick1, joystick2, c);

    local_joy = 6'b111101;
    p1_val    = 8'hFF;
    wait_done(c);
    wait_done(c);
    check("local_merge", int'(joystick1), 'hFD);
    check("p2_unaffected", int'(joystick2), 'h7F);
    $display("merge: joystick1=%h joystick2=%h", joystick1, joystick2);

`ifdef JAMMA_COIN_DEBOUNCE_EN
    jcoin = 2'b10;
    repeat (3) wait_done(c);
    jcoin = 2'b11;
    repeat (2) wait_done(c);
    check("coin_short_glitch", int'(coin), 'b11);
    jcoin = 2'b10;
    repeat (3) wait_done(c);
    check("coin_third_scan", int'(coin), 'b11);
    wait_done(c);
    check("coin_fourth_scan", int'(coin), 'b10);
    $display("debounce: coin=%b", coin);
    jcoin = 2'b11;
`else
    jcoin = 2'b10;
    tick();
    check("coin_lat1", int'(coin), 'b11);
    tick();
    check("coin_lat2", int'(coin), 'b10);
    repeat (11) tick();
    jcoin = 2'b11;
    tick();
    check("coin_back_lat1", int'(coin), 'b10);
    tick();
    check("coin_back_lat2", int'(coin), 'b11);
    $display("coin sync: coin=%b", coin);
`endif

    toggle = 1'b1;
    wait_done(c1);
    wait_done(c2);
    check("half_rate_period", c2 - c1, 36);
    $display("half-rate: period=%0d", c2 - c1);
    toggle = 1'b0;
    ena = 1'b1;

    wait_done(c);
    repeat (12) tick();
    check("in_p2_settle", int'(jselect), 1);
    rst_n = 1'b0;
    #1;
    check("abort_jselect", int'(jselect), 0);
    check("abort_joystick2", int'(joystick2), 'hFF);
    check("abort_joystick1", int'(joystick1), 'hFF);
    repeat (2) tick();
    rst_n = 1'b1;
    wait_done(c);
    check("restart_done_cycle", c, 19);
    $display("reset abort: restart done_cycle=%0d joystick2=%h", c, joystick2);

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jamma_input_scanner.md
JAMMA_INPUT_SCANNER -- requirements
Module: jamma_input_scanner

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 8: enabled cycles to wait after each JSELECT change before sampling; range 1..255.
REQ-002 SHALL have parameter DEBOUNCE_CNT, default 4: consecutive equal scans a coin level must hold before `coin` takes it; range 1..15.
REQ-003 SHALL have port clk, input, 1: the single clock, which is pclk in the top level.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port ena, input, 1: clock enable; all state holds while ena=0.
REQ-006 SHALL have port jjoy, input, 8: multiplexed JAMMA player bus, active-low.
REQ-007 SHALL have port local_joy, input, 6: on-board joystick, active-low, merged into player 1.
REQ-008 SHALL have port jcoin, input, 2: raw coin switches, active-low, asynchronous.
REQ-009 SHALL have port jselect, output, 1: mux select; 0 selects player 1, 1 selects player 2.
REQ-010 SHALL have port joystick1, output, 8: latched player-1 state, active-low.
REQ-011 SHALL have port joystick2, output, 8: latched player-2 state, active-low.
REQ-012 SHALL have port coin, output, 2: conditioned coin state, active-low.
REQ-013 SHALL have port scan_done, output, 1: one-cycle pulse after each complete two-player scan.

Function
REQ-014 SHALL implement an FSM with states P1_SETTLE, P1_SAMPLE, P2_SETTLE, P2_SAMPLE, cycling P1_SETTLE -> P1_SAMPLE -> P2_SETTLE -> P2_SAMPLE -> P1_SETTLE.
REQ-015 SHALL drive jselect=0 in the P1 states and jselect=1 in the P2 states, registered with no glitches.
REQ-016 SHALL remain in each *_SETTLE state for exactly SETTLE_CYCLES enabled cycles, counted by a settle counter cleared on entry.
REQ-017 SHALL spend one enabled cycle in each *_SAMPLE state.
REQ-018 P1_SAMPLE SHALL load joystick1 <= jjoy & {2'b11, local_joy}.
REQ-019 P2_SAMPLE SHALL load joystick2 <= jjoy.
REQ-020 Scan period SHALL be 2*(SETTLE_CYCLES+1) enabled cycles.
REQ-021 scan_done SHALL assert for one clk cycle, in the cycle after the P2_SAMPLE update, and only when ena=1.
REQ-022 joystick1 and joystick2 SHALL change only in their own SAMPLE state and hold otherwise.
REQ-023 jcoin SHALL pass through a two-flop synchronizer before any use.
REQ-024 Each settle counter SHALL wrap only via the state transition; it never overflows.

Reset
REQ-025 On rst_n=0, the block SHALL asynchronously set: state=P1_SETTLE, counters=0, jselect=0, joystick1=joystick2=8'hFF, coin=2'b11, scan_done=0, synchronizer flops=1.
REQ-026 Reset asserted mid-scan SHALL abort the scan with no partial update.
REQ-027 After rst_n rises, the first sample SHALL occur after a full SETTLE_CYCLES.

Configuration
REQ-028 With JAMMA_COIN_DEBOUNCE_EN defined, each coin bit SHALL update only after DEBOUNCE_CNT consecutive P2_SAMPLE scans see the same synchronized level.
REQ-029 With JAMMA_COIN_DEBOUNCE_EN defined, any differing scan SHALL restart that bit's count at 1.
REQ-030 Without JAMMA_COIN_DEBOUNCE_EN, coin SHALL equal the synchronizer output (two-cycle latency) and no debounce logic SHALL be instantiated.

Structure
REQ-031 Package jamma_pkg SHALL hold the FSM state enum, the 8-bit active-low idle constant JOY_IDLE=8'hFF, and the joystick bit-index constants (up/down/left/right/b1/b2/b3/start).
REQ-032 Debounce SHALL be one sub-module, jamma_debounce (per-bit counter), instantiated twice only under the macro.

Verification
REQ-033 SETTLE_CYCLES=8, ena=1, jjoy=8'hFE while jselect=0 and 8'h7F while jselect=1 -> joystick1=8'hFE, joystick2=8'h7F, first scan_done at cycle 19 after reset release, then every 18 cycles.
REQ-034 local_joy=6'b111101, jjoy=8'hFF during P1 -> joystick1=8'hFD; joystick2 unaffected.
REQ-035 ena toggling 1-of-2 cycles -> scan period 36 clk cycles; jselect transitions only on enabled edges.
REQ-036 rst_n pulsed low during P2_SETTLE with joystick2=8'h7F -> joystick2=8'hFF and jselect=0 immediately; no scan_done until a full new scan completes.
REQ-037 JAMMA_COIN_DEBOUNCE_EN, DEBOUNCE_CNT=4, jcoin[0] low for 3 scans then high -> coin stays 2'b11; low for 4 scans -> coin[0]=0 at the 4th scan_done.
REQ-038 Macro undefined, jcoin=2'b10 -> coin=2'b10 exactly two clk cycles later, independent of scan phase.
